serial_word_deser: RTL and testbench
====================================

// Module: serial_word_deser
// PURPOSE
//  Stimulus-side stage that rebuilds parallel words from a 1-bit serial stream.
//  Drives the 9-bit x/y buses of the parser/elaboration test modules.
//  Accumulates WIDTH bits framed by a start marker, then presents the word
//  with a valid/ready handshake. Flags dropped bits (overrun) and broken
//  frames (frame error).
// PARAMETERS
//  WIDTH      9   word width in bits; legal range 2..32
//  LSB_FIRST  1   1: first serial bit lands in m_data[0]; 0: in m_data[WIDTH-1]
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      async active-low reset
//  s_valid    in   1      s_bit/s_start valid this cycle
//  s_bit      in   1      serial data bit
//  s_start    in   1      qualifies s_bit as the first bit of a frame
//  m_data     out  WIDTH  assembled word; stable while m_valid=1
//  m_valid    out  1      word available
//  m_ready    in   1      consumer accepts word when m_valid&&m_ready
//  overrun    out  1      1-cycle pulse: serial bit dropped while in HOLD
//  frame_err  out  1      1-cycle pulse: s_start seen mid-frame
//  busy       out  1      1 while in SHIFT
// BEHAVIOUR
//  Clocking and reset
//  - One clock domain; all state updates on rising clk.
//  - Async reset (rst_n=0): state=IDLE, bit count=0, shift reg=0.
//    m_data=0, m_valid=0, overrun=0, frame_err=0, busy=0.
//  - Reset asserted mid-frame or in HOLD discards the partial or held word.
//  FSM states: IDLE, SHIFT, HOLD.
//  - IDLE:  s_valid&&s_start -> capture bit, cnt=1, go SHIFT.
//           s_valid without s_start -> bit ignored, no flag.
//  - SHIFT: s_valid&&!s_start -> capture bit, cnt+1.
//           Capturing the WIDTH-th bit -> go HOLD; m_data loaded; m_valid=1
//           next cycle (latency: 1 cycle after last bit sampled).
//           s_valid&&s_start -> frame_err pulses next cycle; partial word is
//           discarded; this bit starts a new frame (cnt=1, stay SHIFT).
//           s_valid=0 -> hold; there is no timeout.
//  - HOLD:  m_valid=1 and m_data stable until m_ready.
//           m_valid&&m_ready -> m_valid=0 next cycle.
//           Same-cycle s_valid&&s_start with the handshake -> bit captured
//           (cnt=1), go SHIFT, no flag. Otherwise go IDLE.
//           s_valid while not handshaking -> bit dropped, overrun pulses
//           next cycle.
//           s_valid&&!s_start in the handshake cycle -> dropped, overrun
//           pulses.
//  Bit order
//  - LSB_FIRST=1: bit k of the frame (k=0 first) -> m_data[k].
//  - LSB_FIRST=0: bit k -> m_data[WIDTH-1-k].
//  Counter, flags and outputs
//  - cnt is $clog2(WIDTH+1) bits, cleared on entering HOLD/IDLE, never wraps.
//  - overrun and frame_err are mutually exclusive per cycle and are
//    registered (no combinational path from inputs).
//  - m_ready is ignored while m_valid=0.
//  - busy=1 iff state==SHIFT.
// TESTING
//  1. WIDTH=9, LSB_FIRST=1, m_ready=1; send 1,0,1,0,0,1,0,1,1 with s_start
//     on the first bit -> m_valid=1 one cycle after the 9th bit,
//     m_data=9'h1A5, m_valid=0 the following cycle.
//  2. Same frame with m_ready=0 for 5 cycles -> m_data=9'h1A5 held stable;
//     drive s_valid for 2 of those cycles -> two overrun pulses; data
//     unchanged.
//  3. 4 bits, then s_start with bit=1 -> frame_err single pulse; the next
//     8 bits complete a word whose bit0=1; the discarded bits are absent.
//  4. Back-to-back: handshake cycle coincides with s_start of the next
//     frame -> no overrun; second word 9'h0FF delivered 9 bits later.
//  5. LSB_FIRST=0, frame 1,0,0,0,0,0,0,0,0 -> m_data=9'h100.
//  6. Assert rst_n=0 at bit 5 and during HOLD -> all outputs 0
//     immediately; a fresh frame after release decodes correctly.

Source files
------------

// File: rtl/serial_word_deser.sv
// Serial-to-parallel word assembler.
// Collects WIDTH bits of a frame opened by s_start, then presents the word on a
// valid/ready interface. Dropped bits (overrun) and restarted frames (frame_err)
// are reported as registered single-cycle pulses.
module serial_word_deser #(
    parameter int unsigned WIDTH     = 9,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid_i,
    input  logic             s_bit_i,
    input  logic             s_start_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic             overrun_o,
    output logic             frame_err_o,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic             handshake;
    logic             take_start;
    logic             take_cont;
    logic             last_bit;
    logic [CntW-1:0]  pos_cnt;
    logic [CntW-1:0]  bit_pos;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] word_next;

    // Decode which serial bit, if any, is captured this cycle and where it lands.
    always_comb begin
        handshake  = (state_q == StHold) && m_ready_i;
        // A start bit is accepted anywhere except a HOLD that is not being drained.
        take_start = s_valid_i && s_start_i && ((state_q != StHold) || m_ready_i);
        take_cont  = s_valid_i && !s_start_i && (state_q == StShift);
        last_bit   = take_cont && (cnt_q == CntW'(WIDTH - 1));
        pos_cnt    = take_start ? '0 : cnt_q;
        bit_pos    = LSB_FIRST ? pos_cnt : (CntW'(WIDTH - 1) - pos_cnt);
        bit_mask   = s_bit_i ? (WIDTH'(1) << bit_pos) : '0;
        // A new frame starts from a clean word so stale partial bits never leak.
        word_next  = (take_start ? '0 : shreg_q) | bit_mask;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_start) state_d = StShift;
            end
            StShift: begin
                if (last_bit) state_d = StHold;
            end
            StHold: begin
                if (handshake) state_d = take_start ? StShift : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: bit counter, shift word, output word and flags.
    always_comb begin
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        m_data_d    = m_data_q;
        if (take_start) begin
            cnt_d   = CntW'(1);
            shreg_d = word_next;
        end else if (last_bit) begin
            cnt_d    = '0;
            shreg_d  = '0;
            m_data_d = word_next;
        end else if (take_cont) begin
            cnt_d   = cnt_q + CntW'(1);
            shreg_d = word_next;
        end
        // Different source states, so the two flags can never coincide.
        frame_err_d = take_start && (state_q == StShift);
        overrun_d   = (state_q == StHold) && s_valid_i && !take_start;
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            m_data_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            m_data_q    <= m_data_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Outputs: all driven from registers only.
    always_comb begin
        m_data_o    = m_data_q;
        m_valid_o   = (state_q == StHold);
        busy_o      = (state_q == StShift);
        overrun_o   = overrun_q;
        frame_err_o = frame_err_q;
    end

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed and random bench for serial_word_deser; two instances share the
// serial inputs so both bit orders are observed on every cycle.
module tb_serial_word_deser;

    localparam int W = 9;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic s_valid = 1'b0;
    logic s_bit = 1'b0;
    logic s_start = 1'b0;
    logic m_ready = 1'b0;

    logic [W-1:0] data_l, data_m;
    logic valid_l, valid_m, ovr_l, ovr_m, fe_l, fe_m, busy_l, busy_m;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: bits of the open frame, held-word flag, last words, flags.
    bit          fbits[$];
    bit          m_hold;
    logic [31:0] e_dl, e_dm;
    bit          e_ovr, e_fe;

    always #5 clk = ~clk;

    serial_word_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
        .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(s_valid), .s_bit_i(s_bit),
        .s_start_i(s_start), .m_data_o(data_l), .m_valid_o(valid_l), .m_ready_i(m_ready),
        .overrun_o(ovr_l), .frame_err_o(fe_l), .busy_o(busy_l)
    );

    serial_word_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
        .clk_i(clk), .rst_ni(rst_ni), .s_valid_i(s_valid), .s_bit_i(s_bit),
        .s_start_i(s_start), .m_data_o(data_m), .m_valid_o(valid_m), .m_ready_i(m_ready),
        .overrun_o(ovr_m), .frame_err_o(fe_m), .busy_o(busy_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pack(input bit lsb);
        logic [31:0] w = 0;
        for (int k = 0; k < W; k++)
            if (fbits[k]) w = w | (32'd1 << (lsb ? k : (W - 1 - k)));
        return w;
    endfunction

    task automatic model_clear();
        fbits.delete();
        m_hold = 0;
        e_dl = 0;
        e_dm = 0;
        e_ovr = 0;
        e_fe = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit st, input bit rdy);
        e_ovr = 0;
        e_fe = 0;
        if (m_hold) begin
            if (rdy) begin
                m_hold = 0;
                if (v && st) fbits.push_back(b);
                else if (v) e_ovr = 1;
            end else if (v) begin
                e_ovr = 1;
            end
        end else if (v) begin
            if (st) begin
                if (fbits.size() > 0) e_fe = 1;
                fbits.delete();
                fbits.push_back(b);
            end else if (fbits.size() > 0) begin
                fbits.push_back(b);
                if (fbits.size() == W) begin
                    e_dl = pack(1'b1);
                    e_dm = pack(1'b0);
                    m_hold = 1;
                    fbits.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_busy;
        e_busy = (fbits.size() > 0) ? 32'd1 : 32'd0;
        chk({tag, " valid_l"}, valid_l, m_hold);
        chk({tag, " valid_m"}, valid_m, m_hold);
        chk({tag, " data_l"}, data_l, e_dl);
        chk({tag, " data_m"}, data_m, e_dm);
        chk({tag, " ovr_l"}, ovr_l, e_ovr);
        chk({tag, " ovr_m"}, ovr_m, e_ovr);
        chk({tag, " fe_l"}, fe_l, e_fe);
        chk({tag, " fe_m"}, fe_m, e_fe);
        chk({tag, " busy_l"}, busy_l, e_busy);
        chk({tag, " busy_m"}, busy_m, e_busy);
    endtask

    // One clock: drive inputs, advance model on the edge, check 1 time unit later.
    task automatic cyc(input bit v, input bit b, input bit st, input bit rdy, input string tag);
        s_valid = v;
        s_bit = b;
        s_start = st;
        m_ready = rdy;
        @(posedge clk);
        model_step(v, b, st, rdy);
        #1;
        check_all(tag);
    endtask

    // Send n bits, bit k taken from bits[k]; first carries s_start when asked.
    task automatic send(input logic [31:0] bits, input int n, input bit first_start,
                        input bit rdy, input string tag);
        for (int k = 0; k < n; k++) cyc(1'b1, bits[k], first_start && (k == 0), rdy, tag);
    endtask

    task automatic async_reset(input string tag);
        s_valid = 0;
        s_bit = 0;
        s_start = 0;
        m_ready = 0;
        #2;
        rst_ni = 0;
        #1;
        model_clear();
        check_all(tag);
        chk({tag, " data0"}, data_l, 32'h0);
        chk({tag, " valid0"}, valid_l, 32'h0);
        @(posedge clk);
        #1;
        rst_ni = 1;
    endtask

    int ovr_cnt;

    initial begin
        model_clear();
        #2;
        check_all("por");
        @(posedge clk);
        #1;
        rst_ni = 1;

        // Basic frame, consumer always ready.
        send(32'h1A5, W, 1'b1, 1'b1, "t1");
        chk("t1 valid", valid_l, 32'h1);
        chk("t1 word", data_l, 32'h1A5);
        cyc(0, 0, 0, 1, "t1 drain");
        chk("t1 valid drop", valid_l, 32'h0);

        // Back-pressure: word held, two bits dropped with overrun.
        send(32'h1A5, W, 1'b1, 1'b0, "t2");
        ovr_cnt = 0;
        cyc(1, 0, 0, 0, "t2 h");  ovr_cnt += int'(ovr_l);
        cyc(0, 0, 0, 0, "t2 h");  ovr_cnt += int'(ovr_l);
        cyc(1, 1, 1, 0, "t2 h");  ovr_cnt += int'(ovr_l);
        cyc(0, 0, 0, 0, "t2 h");  ovr_cnt += int'(ovr_l);
        cyc(0, 0, 0, 0, "t2 h");  ovr_cnt += int'(ovr_l);
        chk("t2 overrun pulses", ovr_cnt, 32'd2);
        chk("t2 word held", data_l, 32'h1A5);
        chk("t2 still valid", valid_l, 32'h1);
        cyc(0, 0, 0, 1, "t2 drain");

        // Frame restarted mid-way: discarded bits never reach the word.
        send(32'h0B, 4, 1'b1, 1'b1, "t3 part");
        cyc(1, 1, 1, 1, "t3 restart");
        chk("t3 frame_err", fe_l, 32'h1);
        send(32'h5A, 8, 1'b0, 1'b1, "t3 rest");
        chk("t3 word", data_l, 32'h0B5);
        cyc(0, 0, 0, 1, "t3 drain");

        // Back-to-back: handshake cycle carries the next start bit.
        send(32'h1A5, W, 1'b1, 1'b0, "t4 a");
        cyc(1, 1, 1, 1, "t4 hs");
        chk("t4 no overrun", ovr_l, 32'h0);
        chk("t4 busy", busy_l, 32'h1);
        send(32'h7F, 8, 1'b0, 1'b1, "t4 b");
        chk("t4 word", data_l, 32'h0FF);
        cyc(0, 0, 0, 1, "t4 drain");

        // MSB-first ordering.
        send(32'h001, W, 1'b1, 1'b1, "t5");
        chk("t5 msb word", data_m, 32'h100);
        chk("t5 lsb word", data_l, 32'h001);
        cyc(0, 0, 0, 1, "t5 drain");

        // Reset mid-frame and in HOLD, then a fresh frame.
        send(32'h15, 5, 1'b1, 1'b1, "t6 part");
        async_reset("t6 rst shift");
        send(32'h1A5, W, 1'b1, 1'b0, "t6 hold");
        async_reset("t6 rst hold");
        send(32'h0C3, W, 1'b1, 1'b1, "t6 fresh");
        chk("t6 word", data_l, 32'h0C3);
        cyc(0, 0, 0, 1, "t6 drain");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) != 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
